// File: rtl/pll_sup_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
// The state encoding is shared so the supervisor and its users agree on the decode.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      HOLDOFF,
      RUN,
      FAULT
   } state_t;

   // Bits needed to hold every value in 0..max_value; never less than one bit.
   function automatic int width_for(input int max_value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) <= max_value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous level signals into a clock domain.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up controller: pulses the PLL reset, waits for a qualified lock with timeout
// and retries, then releases sys_rst to the PLL-clocked logic. Runs on the PLL reference clock.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int HOLDOFF_CYCLES      = 1024,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 20
) (
   input  logic                                refclk,
   input  logic                                rst,
   input  logic                                pll_locked,
   input  logic                                restart,
   output logic                                pll_rst,
   output logic                                sys_rst,
   output logic                                ready,
   output logic                                fault,
   output logic                                lock_lost,
   output logic [width_for(MAX_RETRIES)-1:0]   retry_count
);

   localparam int RETRY_W = width_for(MAX_RETRIES);

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [RETRY_W-1:0] retry_next;
   logic               lock_lost_next;
   logic               locked_s;

   sync_2ff #(
      .WIDTH(1)
   ) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // One shared counter serves the reset pulse, the lock timeout and the holdoff;
   // each terminal compare happens before the increment so the counter never wraps.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      retry_next     = retry_count;
      lock_lost_next = 1'b0;

      if (restart) begin
         state_next = RESET_PLL;
         cnt_next   = '0;
         retry_next = '0;
      end else begin
         case (state)
            RESET_PLL: begin
               if (cnt == RST_LAST) begin
                  state_next = WAIT_LOCK;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_next = HOLDOFF;
                  cnt_next   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_next = '0;
                  if (retry_count < RETRY_MAX) begin
                     retry_next = retry_count + RETRY_W'(1);
                     state_next = RESET_PLL;
                  end else begin
                     state_next = FAULT;
                  end
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            HOLDOFF: begin
               if (!locked_s) begin
                  state_next = WAIT_LOCK;
                  cnt_next   = '0;
               end else if (cnt == HOLD_LAST) begin
                  state_next = RUN;
                  cnt_next   = '0;
                  retry_next = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!locked_s) begin
                  lock_lost_next = 1'b1;
                  state_next     = RESET_PLL;
                  cnt_next       = '0;
                  retry_next     = '0;
               end
            end
            FAULT: begin
               state_next = FAULT;
            end
            default: begin
               state_next = RESET_PLL;
               cnt_next   = '0;
               retry_next = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state       <= RESET_PLL;
         cnt         <= '0;
         retry_count <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         fault       <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         retry_count <= retry_next;
         pll_rst     <= (state_next == RESET_PLL) || (state_next == FAULT);
         sys_rst     <= (state_next != RUN);
         ready       <= (state_next == RUN);
         fault       <= (state_next == FAULT);
         lock_lost   <= lock_lost_next;
      end
   end

endmodule
